// File: rtl/key_led_pkg.sv
// Shared types for the key/LED pattern block: mode encoding and the
// mapping from key index to the mode it selects.
package key_led_pkg;

  localparam int NUM_KEYS = 4;
  localparam int MODE_W   = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF     = 3'd0,
    MODE_SHIFT_L = 3'd1,
    MODE_SHIFT_R = 3'd2,
    MODE_BLINK   = 3'd3,
    MODE_ALL_ON  = 3'd4
  } mode_e;

  // key0..key3 select SHIFT_L, SHIFT_R, BLINK, ALL_ON
  function automatic mode_e key_to_mode(input int idx);
    case (idx)
      0:       return MODE_SHIFT_L;
      1:       return MODE_SHIFT_R;
      2:       return MODE_BLINK;
      3:       return MODE_ALL_ON;
      default: return MODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchroniser, mismatch-run debounce counter and a
// one-cycle press pulse on the debounced falling edge.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  logic             deb;
  logic             deb_q;

  // bring the asynchronous pin into the clock domain; idle level is 1
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) sync <= 2'b11;
    else            sync <= {sync[0], key};
  end

  // accept a new level only after it has differed for DEBOUNCE_CYCLES edges
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= '0;
      deb <= 1'b1;
    end else if (sync[1] == deb) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      deb <= sync[1];
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // previous debounced level, for edge detection
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) deb_q <= 1'b1;
    else            deb_q <= deb;
  end

  // high for the single cycle after the debounced level falls
  assign press = deb_q & ~deb;

endmodule

// File: rtl/key_led_pattern.sv
// Debounced key-latched mode selection driving an N-LED pattern generator.
// Optional build macro KEY_LED_PWM_EN dims every LED with a fixed-duty PWM;
// without it the pattern drives the LEDs directly.
module key_led_pattern
  import key_led_pkg::*;
#(
  parameter int NUM_LEDS        = 4,
  parameter int STEP_CYCLES     = 10_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int PWM_PERIOD      = 256,
  parameter int PWM_DUTY        = 64
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [3:0]          key,
  output logic [NUM_LEDS-1:0] led,
  output logic [2:0]          mode
);

  localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int PH_W   = $clog2(NUM_LEDS);
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [PH_W-1:0]     PH_LAST   = PH_W'(NUM_LEDS - 1);
  localparam logic [NUM_LEDS-1:0] LSB_ONLY  = NUM_LEDS'(1);
  localparam logic [NUM_LEDS-1:0] MSB_ONLY  = LSB_ONLY << (NUM_LEDS - 1);

  // reject configurations the counters cannot represent
  if (NUM_LEDS < 2 || NUM_LEDS > 16 || STEP_CYCLES < 1 || DEBOUNCE_CYCLES < 1 ||
      PWM_PERIOD < 1 || PWM_DUTY < 0 || PWM_DUTY > PWM_PERIOD) begin : g_bad_cfg
    $error("key_led_pattern: parameter out of range");
  end

  logic [NUM_KEYS-1:0] press;
  mode_e               mode_q, mode_nxt;
  logic                mode_chg;
  logic [STEP_W-1:0]   step_cnt;
  logic                tick;
  logic [PH_W-1:0]     phase;
  logic                blink;
  logic [NUM_LEDS-1:0] pat;
  logic [NUM_LEDS-1:0] pwm_mask;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .key       (key[k]),
      .press     (press[k])
    );
  end

  // mode state register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) mode_q <= MODE_OFF;
    else            mode_q <= mode_nxt;
  end

  // next mode: lowest pressed key wins; re-pressing the active key turns off.
  // Every accepted press changes the mode since key modes are never OFF.
  always_comb begin
    mode_nxt = mode_q;
    mode_chg = 1'b0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (press[k]) begin
        mode_chg = 1'b1;
        mode_nxt = (key_to_mode(k) == mode_q) ? MODE_OFF : key_to_mode(k);
      end
    end
  end

  assign mode = mode_q;
  assign tick = (step_cnt == STEP_LAST);

  // step timebase, phase and blink run in every mode; a mode change restarts them
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      step_cnt <= '0;
      phase    <= '0;
      blink    <= 1'b0;
    end else if (mode_chg) begin
      step_cnt <= '0;
      phase    <= '0;
      blink    <= 1'b0;
    end else begin
      step_cnt <= tick ? '0 : step_cnt + 1'b1;
      if (tick) begin
        phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
        blink <= ~blink;
      end
    end
  end

  // pattern selected by the current mode
  always_comb begin
    pat = '0;
    case (mode_q)
      MODE_SHIFT_L: pat = MSB_ONLY >> phase;
      MODE_SHIFT_R: pat = LSB_ONLY << phase;
      MODE_BLINK:   pat = blink ? '0 : '1;
      MODE_ALL_ON:  pat = '1;
      default:      pat = '0;
    endcase
  end

`ifdef KEY_LED_PWM_EN
  localparam int PWM_W = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam logic [PWM_W-1:0] PWM_LAST = PWM_W'(PWM_PERIOD - 1);

  logic [PWM_W-1:0] pwm_cnt;

  // free-running PWM frame counter
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) pwm_cnt <= '0;
    else            pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
  end

  assign pwm_mask = {NUM_LEDS{32'(pwm_cnt) < PWM_DUTY}};
`else
  assign pwm_mask = '1;
`endif

  // registered LED drive
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) led <= '0;
    else            led <= pat & pwm_mask;
  end

endmodule

// File: tb/tb_key_led_pattern.sv
// Scoreboard bench for key_led_pattern: a behavioural model pushes the
// expected led/mode for every clock edge, a monitor pops and compares.
module tb_key_led_pattern;
  import key_led_pkg::*;

  localparam int N = 5, S = 8, D = 4, P = 4, DUTY = 1;

  logic         sys_clk = 1'b0;
  logic         sys_rst_n = 1'b0;
  logic [3:0]   key = 4'hF;
  logic [N-1:0] led;
  logic [2:0]   mode;

  int checks = 0;
  int failures = 0;

  key_led_pattern #(
    .NUM_LEDS(N), .STEP_CYCLES(S), .DEBOUNCE_CYCLES(D),
    .PWM_PERIOD(P), .PWM_DUTY(DUTY)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key       (key),
    .led       (led),
    .mode      (mode)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [N-1:0] led; logic [2:0] mode; } exp_t;
  exp_t sb_q[$];

  logic [3:0] seen[$];      // key samples; the debouncer acts on the one from two edges back
  int         run[4];       // consecutive edges the delayed key disagreed with the accepted level
  logic [3:0] m_level;      // accepted (debounced) key levels
  logic [3:0] m_fell;       // keys whose accepted level fell at the last edge
  int         m_mode;
  int         m_t;          // edges since the pattern timebase last restarted
  int         m_edges;      // edges since reset (PWM frame position)

  function automatic logic [N-1:0] ref_pattern(input int md, input int ticks);
    logic [N-1:0] one = 1;
    case (md)
      1:       return one << (N - 1 - ticks % N);
      2:       return one << (ticks % N);
      3:       return (ticks % 2 == 0) ? '1 : '0;
      4:       return '1;
      default: return '0;
    endcase
  endfunction

  task automatic model_reset();
    seen.delete();
    seen.push_back(4'hF);
    seen.push_back(4'hF);
    for (int k = 0; k < 4; k++) run[k] = 0;
    m_level = 4'hF;
    m_fell  = 4'h0;
    m_mode  = 0;
    m_t     = 0;
    m_edges = 0;
    sb_q.delete();
  endtask

  initial model_reset();

  always @(posedge sys_clk or negedge sys_rst_n) begin
    exp_t e;
    logic [3:0] dv;
    if (!sys_rst_n) begin
      model_reset();
    end else begin
      // LEDs show the pattern of the state held before this edge
      e.led = ref_pattern(m_mode, m_t / S);
`ifdef KEY_LED_PWM_EN
      if (m_edges % P >= DUTY) e.led = '0;
`endif
      // a press seen at the previous edge selects the new mode now
      if (m_fell != 4'h0) begin
        int km;
        km = 0;
        for (int k = 3; k >= 0; k--) if (m_fell[k]) km = k + 1;
        m_mode = (m_mode == km) ? 0 : km;
        m_t = 0;
      end else begin
        m_t++;
      end
      e.mode = 3'(m_mode);
      // debounce: accept a level that has disagreed for D edges in a row
      dv = seen[0];
      m_fell = 4'h0;
      for (int k = 0; k < 4; k++) begin
        if (dv[k] == m_level[k]) run[k] = 0;
        else begin
          run[k]++;
          if (run[k] == D) begin
            m_level[k] = dv[k];
            run[k] = 0;
            if (!dv[k]) m_fell[k] = 1'b1;
          end
        end
      end
      seen.push_back(key);
      void'(seen.pop_front());
      m_edges++;
      sb_q.push_back(e);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge sys_clk) begin
    exp_t e;
    if (!sys_rst_n) begin
      check("reset_led", 32'(led), 32'd0);
      check("reset_mode", 32'(mode), 32'd0);
    end else if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("sb_led", 32'(led), 32'(e.led));
      check("sb_mode", 32'(mode), 32'(e.mode));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick_n(input int n);
    repeat (n) begin @(posedge sys_clk); #1; end
  endtask

  task automatic drive(input logic [3:0] v);
    @(posedge sys_clk); #1 key = v;
  endtask

  task automatic edges_until_mode(input int want, input int limit, output int n);
    n = 0;
    while (32'(mode) != want && n < limit) begin @(posedge sys_clk); #1; n++; end
  endtask

  task automatic press_key(input logic [3:0] pressed, input int hold);
    drive(~pressed);
    tick_n(hold);
    key = 4'hF;
    tick_n(12);
  endtask

  initial begin
    int n, on_cnt, off_cnt;
    // 1: reset state
    tick_n(3);
    sys_rst_n = 1'b1;
    tick_n(4);

    // 2: key0 held -> mode at edge 7, MSB-only at edge 8, then shifts right
    drive(4'b1110);
    edges_until_mode(1, 20, n);
    check("key0_mode_latency", 32'(n), 32'd7);
    check("key0_mode", 32'(mode), 32'd1);
    tick_n(1);
`ifndef KEY_LED_PWM_EN
    check("key0_first_led", 32'(led), 32'b10000);
    tick_n(8);
    check("key0_second_led", 32'(led), 32'b01000);
`endif
    tick_n(500);
    check("key0_hold_no_repeat", 32'(mode), 32'd1);
    key = 4'hF;
    tick_n(12);
    press_key(4'b0001, 10);
    check("key0_toggle_off", 32'(mode), 32'd0);

    // 3: short key1 bounces are rejected, a steady hold is accepted
    for (int i = 0; i < 4; i++) begin
      drive(4'b1101); tick_n(2);
      drive(4'b1111);
    end
    tick_n(10);
    check("key1_bounce_rejected", 32'(mode), 32'd0);
    drive(4'b1101);
    edges_until_mode(2, 20, n);
    check("key1_hold_mode", 32'(mode), 32'd2);
    tick_n(1);
`ifndef KEY_LED_PWM_EN
    check("key1_first_led", 32'(led), 32'b00001);
`endif
    key = 4'hF;
    tick_n(12);

    // 4: BLINK across the phase wrap, then toggle off
    press_key(4'b0100, 10);
    check("key2_blink_mode", 32'(mode), 32'd3);
    tick_n(90);
    press_key(4'b0100, 10);
    check("key2_toggle_off", 32'(mode), 32'd0);
    tick_n(2);
    check("key2_off_led", 32'(led), 32'd0);

    // 5: simultaneous key1+key3 -> lowest index wins, then key3
    press_key(4'b1010, 10);
    check("simul_low_wins", 32'(mode), 32'd2);
    press_key(4'b1000, 10);
    check("key3_all_on", 32'(mode), 32'd4);

    // 6: ALL_ON output over two PWM frames
    on_cnt = 0; off_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      if (led == 5'b11111) on_cnt++;
      if (led == 5'b00000) off_cnt++;
    end
`ifdef KEY_LED_PWM_EN
    check("pwm_on_cycles", 32'(on_cnt), 32'd2);
    check("pwm_off_cycles", 32'(off_cnt), 32'd6);
`else
    check("all_on_steady", 32'(on_cnt), 32'd8);
`endif
    tick_n(1);

    // 1b: asynchronous reset while in BLINK with LEDs lit
    press_key(4'b0100, 10);
    n = 0;
    while (led == '0 && n < 40) begin @(posedge sys_clk); #1; n++; end
    check("blink_lit_before_reset", 32'(led != '0), 32'd1);
    #2 sys_rst_n = 1'b0;
    #1;
    check("async_reset_led", 32'(led), 32'd0);
    check("async_reset_mode", 32'(mode), 32'd0);
    tick_n(2);
    sys_rst_n = 1'b1;
    tick_n(4);

    // random key activity against the model
    for (int i = 0; i < 80; i++) begin
      drive(4'($urandom_range(0, 15)));
      tick_n($urandom_range(0, 14));
    end
    key = 4'hF;
    tick_n(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
